// File: rtl/bypass_rf_wb_ctrl_pkg.sv
// Shared defaults and per-name lifecycle encoding for the bypassing register file
// writeback/free controller and its benches.
package bypass_rf_wb_ctrl_pkg;

  localparam int DEF_NAME_W  = 2;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_NUM_REQ = 4;

  typedef enum logic [1:0] {
    NS_IDLE  = 2'd0,
    NS_ALLOC = 2'd1,
    NS_DONE  = 2'd2
  } name_state_e;

  function automatic name_state_e name_state(input logic alloc_v, input logic written,
                                             input logic retired);
    if (!alloc_v)              return NS_IDLE;
    else if (written && retired) return NS_DONE;
    else                       return NS_ALLOC;
  endfunction

endpackage

// File: rtl/bypass_rf_wb_ctrl_if.sv
// Writeback, alloc/retire and free-port signals between the pipeline, the
// controller (slave) and the environment/register file (master).
interface bypass_rf_wb_ctrl_if #(
  parameter int name_width = 2,
  parameter int data_width = 32,
  parameter int num_req    = 4
);
  logic [num_req-1:0]            REQ_VALID;
  logic [num_req*name_width-1:0] REQ_NAME;
  logic [num_req*data_width-1:0] REQ_DATA;
  logic [num_req-1:0]            REQ_READY;
  logic [name_width-1:0]         NAME_IN_1, NAME_IN_2;
  logic [data_width-1:0]         D_IN_1, D_IN_2;
  logic                          WE_1, WE_2;
  logic                          ALLOC_FIRE;
  logic [name_width-1:0]         ALLOC_NAME;
  logic                          RET_VALID;
  logic [name_width-1:0]         RET_NAME;
  logic [name_width-1:0]         W_F;
  logic                          WFE;
  logic                          F_READY;
  logic [name_width:0]           PENDING;
  logic                          ERR;

  modport slave (
    input  REQ_VALID, REQ_NAME, REQ_DATA, ALLOC_FIRE, ALLOC_NAME, RET_VALID, RET_NAME, F_READY,
    output REQ_READY, NAME_IN_1, NAME_IN_2, D_IN_1, D_IN_2, WE_1, WE_2, W_F, WFE, PENDING, ERR
  );

  modport master (
    output REQ_VALID, REQ_NAME, REQ_DATA, ALLOC_FIRE, ALLOC_NAME, RET_VALID, RET_NAME, F_READY,
    input  REQ_READY, NAME_IN_1, NAME_IN_2, D_IN_1, D_IN_2, WE_1, WE_2, W_F, WFE, PENDING, ERR
  );
endinterface

// File: rtl/bypass_rf_wb_ctrl_rr_pick2.sv
// Two-grant round-robin picker: first valid from i_ptr wins port 1; the next valid
// whose name differs from the winner's (exclusion mask) wins port 2.
module bypass_rf_wb_ctrl_rr_pick2 #(
  parameter int N  = 4,
  parameter int NW = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    i_req,
  input  logic [N*NW-1:0] i_name,
  input  logic [IW-1:0]   i_ptr,
  output logic            o_v1,
  output logic            o_v2,
  output logic [IW-1:0]   o_idx1,
  output logic [IW-1:0]   o_idx2,
  output logic [N-1:0]    o_gnt1,
  output logic [N-1:0]    o_gnt2
);

  logic [N-1:0] w_excl;

  function automatic logic [IW:0] first(input logic [N-1:0] req, input logic [IW-1:0] ptr);
    logic [IW:0] r;
    int j;
    r = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j] && !r[IW]) r = {1'b1, IW'(j)};
    end
    return r;
  endfunction

  always_comb begin
    w_excl = '0;
    {o_v1, o_idx1} = first(i_req, i_ptr);
    for (int j = 0; j < N; j++)
      w_excl[j] = (i_name[j*NW +: NW] == i_name[int'(o_idx1)*NW +: NW]);
    {o_v2, o_idx2} = first(i_req & ~w_excl, i_ptr);
    o_gnt1 = o_v1 ? (N'(1) << o_idx1) : '0;
    o_gnt2 = o_v2 ? (N'(1) << o_idx2) : '0;
  end

endmodule

// File: rtl/bypass_rf_wb_ctrl.sv
// Writeback arbiter and in-order free sequencer for the bypassing register file.
// Optional protocol checker (sticky ERR) enabled by BYPASS_RF_WB_CTRL_CHECK_EN.
module bypass_rf_wb_ctrl
  import bypass_rf_wb_ctrl_pkg::*;
#(
  parameter int name_width = DEF_NAME_W,
  parameter int data_width = DEF_DATA_W,
  parameter int num_req    = DEF_NUM_REQ
) (
  input logic CLK,
  input logic RST,
  bypass_rf_wb_ctrl_if.slave bus
);

  localparam int NN = 1 << name_width;
  localparam int IW = (num_req > 1) ? $clog2(num_req) : 1;
  localparam logic [name_width:0] P_MAX = (name_width+1)'(NN);

  logic [num_req-1:0]    w_req, w_gnt1, w_gnt2;
  logic                  w_v1, w_v2, w_done, w_free;
  logic [IW-1:0]         w_idx1, w_idx2;
  logic [name_width-1:0] w_name1, w_name2;
  logic [data_width-1:0] w_d1, w_d2;

  logic [IW-1:0]         r_rr_ptr;
  logic [name_width-1:0] r_free_ptr, r_name1, r_name2;
  logic [NN-1:0]         r_alloc_v, r_written, r_retired;
  logic                  r_we1, r_we2;
  logic [data_width-1:0] r_d1, r_d2;
  logic [name_width:0]   r_pending;

  function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] idx);
    return (int'(idx) == num_req - 1) ? '0 : idx + 1'b1;
  endfunction

  assign w_req = bus.REQ_VALID & {num_req{RST}};

  bypass_rf_wb_ctrl_rr_pick2 #(.N(num_req), .NW(name_width), .IW(IW)) u_pick (
    .i_req(w_req), .i_name(bus.REQ_NAME), .i_ptr(r_rr_ptr),
    .o_v1(w_v1), .o_v2(w_v2), .o_idx1(w_idx1), .o_idx2(w_idx2),
    .o_gnt1(w_gnt1), .o_gnt2(w_gnt2)
  );

  assign w_name1 = bus.REQ_NAME[int'(w_idx1)*name_width +: name_width];
  assign w_name2 = bus.REQ_NAME[int'(w_idx2)*name_width +: name_width];
  assign w_d1    = bus.REQ_DATA[int'(w_idx1)*data_width +: data_width];
  assign w_d2    = bus.REQ_DATA[int'(w_idx2)*data_width +: data_width];

  assign bus.REQ_READY = w_gnt1 | w_gnt2;
  assign bus.WE_1      = r_we1;
  assign bus.WE_2      = r_we2;
  assign bus.NAME_IN_1 = r_name1;
  assign bus.NAME_IN_2 = r_name2;
  assign bus.D_IN_1    = r_d1;
  assign bus.D_IN_2    = r_d2;

  // Frees are strictly in allocation order: only the name at free_ptr is considered.
  assign w_done      = name_state(r_alloc_v[r_free_ptr], r_written[r_free_ptr],
                                  r_retired[r_free_ptr]) == NS_DONE;
  assign bus.WFE     = RST & w_done;
  assign bus.W_F     = r_free_ptr;
  assign w_free      = bus.WFE & bus.F_READY;
  assign bus.PENDING = r_pending;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_we1 <= 1'b0; r_we2 <= 1'b0;
      r_name1 <= '0; r_name2 <= '0;
      r_d1 <= '0;    r_d2 <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_we1 <= w_v1;
      r_we2 <= w_v2;
      if (w_v1) begin r_name1 <= w_name1; r_d1 <= w_d1; end
      if (w_v2) begin r_name2 <= w_name2; r_d2 <= w_d2; end
      if (w_v2)      r_rr_ptr <= rr_next(w_idx2);
      else if (w_v1) r_rr_ptr <= rr_next(w_idx1);
    end
  end

  // written is set as the file commits, i.e. at the end of the cycle WE_x is high.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_alloc_v <= '0; r_written <= '0; r_retired <= '0;
      r_free_ptr <= '0;
      r_pending <= '0;
    end else begin
      if (bus.ALLOC_FIRE) begin
        r_alloc_v[bus.ALLOC_NAME] <= 1'b1;
        r_written[bus.ALLOC_NAME] <= 1'b0;
        r_retired[bus.ALLOC_NAME] <= 1'b0;
      end
      if (r_we1) r_written[r_name1] <= 1'b1;
      if (r_we2) r_written[r_name2] <= 1'b1;
      if (bus.RET_VALID) r_retired[bus.RET_NAME] <= 1'b1;
      if (w_free) begin
        r_alloc_v[r_free_ptr] <= 1'b0;
        r_written[r_free_ptr] <= 1'b0;
        r_retired[r_free_ptr] <= 1'b0;
        r_free_ptr <= r_free_ptr + 1'b1;
      end
      case ({bus.ALLOC_FIRE, w_free})
        2'b10:   if (r_pending != P_MAX) r_pending <= r_pending + 1'b1;
        2'b01:   if (r_pending != '0)    r_pending <= r_pending - 1'b1;
        default: r_pending <= r_pending;
      endcase
    end
  end

`ifdef BYPASS_RF_WB_CTRL_CHECK_EN
  logic w_bad, r_err;
  always_comb begin
    w_bad = 1'b0;
    if (w_v1 && (!r_alloc_v[w_name1] || r_written[w_name1])) w_bad = 1'b1;
    if (w_v2 && (!r_alloc_v[w_name2] || r_written[w_name2])) w_bad = 1'b1;
    if (bus.RET_VALID && !r_alloc_v[bus.RET_NAME])           w_bad = 1'b1;
    if (bus.ALLOC_FIRE && r_alloc_v[bus.ALLOC_NAME])         w_bad = 1'b1;
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)       r_err <= 1'b0;
    else if (w_bad) r_err <= 1'b1;
  end
  assign bus.ERR = r_err;
`else
  assign bus.ERR = 1'b0;
`endif

endmodule

// File: tb/tb_bypass_rf_wb_ctrl.sv
// Random + directed scoreboard bench: a driver predicts grants/frees from a queue-based
// name lifecycle model and queues expected writes; a monitor checks the write ports.
module tb_bypass_rf_wb_ctrl;
  import bypass_rf_wb_ctrl_pkg::*;

  localparam int NW = 2, DW = 32, NR = 4, NN = 4;
  localparam int INF = 1 << 30;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  bypass_rf_wb_ctrl_if #(.name_width(NW), .data_width(DW), .num_req(NR)) bus();
  bypass_rf_wb_ctrl #(.name_width(NW), .data_width(DW), .num_req(NR)) dut (
    .CLK(CLK), .RST(RST), .bus(bus)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [NW-1:0] name; logic [DW-1:0] data; } wr_t;
  wr_t q1[$], q2[$];

  int errors = 0, checks = 0;

  // reference model: allocation-ordered queue plus per-name commit time and retire flag
  int alloc_q[$];
  int wr_at[NN];
  bit ret[NN];
  int rr, frees, cyc;
  bit err_exp;

  logic [NR-1:0] s_v;
  logic [NW-1:0] s_n[NR];
  logic [DW-1:0] s_d[NR];
  logic          s_af, s_rv, s_fr;
  logic [NW-1:0] s_rn, s_an;

  function automatic bit chk_en();
`ifdef BYPASS_RF_WB_CTRL_CHECK_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit is_alloc(input int n);
    foreach (alloc_q[i]) if (alloc_q[i] == n) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    alloc_q.delete(); q1.delete(); q2.delete();
    for (int i = 0; i < NN; i++) begin wr_at[i] = INF; ret[i] = 1'b0; end
    rr = 0; frees = 0; err_exp = 1'b0;
  endtask

  task automatic clr();
    s_v = '0; s_af = 1'b0; s_rv = 1'b0; s_fr = 1'b1; s_rn = '0;
    for (int i = 0; i < NR; i++) begin s_n[i] = '0; s_d[i] = '0; end
  endtask

  task automatic drive();
    bus.REQ_VALID  = s_v;
    for (int i = 0; i < NR; i++) begin
      bus.REQ_NAME[i*NW +: NW] = s_n[i];
      bus.REQ_DATA[i*DW +: DW] = s_d[i];
    end
    bus.ALLOC_FIRE = s_af;
    bus.ALLOC_NAME = s_an;
    bus.RET_VALID  = s_rv;
    bus.RET_NAME   = s_rn;
    bus.F_READY    = s_fr;
  endtask

  task automatic accept(input int p, input int port);
    wr_t e;
    int n;
    if (p < 0) return;
    n = int'(s_n[p]);
    e.name = s_n[p]; e.data = s_d[p];
    if (port == 1) q1.push_back(e); else q2.push_back(e);
    if (!is_alloc(n) || wr_at[n] <= cyc) err_exp |= chk_en();
    if (wr_at[n] > cyc + 2) wr_at[n] = cyc + 2;
  endtask

  task automatic step();
    int p1, p2, j, f, last;
    bit wfe_e;
    logic [NR-1:0] rdy_e;
    @(negedge CLK); #1;
    s_an = NW'((frees + alloc_q.size()) % NN);
    drive();
    #1;
    p1 = -1; p2 = -1;
    for (int k = 0; k < NR; k++) begin
      j = (rr + k) % NR;
      if (s_v[j]) begin
        if (p1 < 0) p1 = j;
        else if (p2 < 0 && s_n[j] != s_n[p1]) p2 = j;
      end
    end
    rdy_e = '0;
    if (p1 >= 0) rdy_e[p1] = 1'b1;
    if (p2 >= 0) rdy_e[p2] = 1'b1;
    f = (alloc_q.size() != 0) ? alloc_q[0] : -1;
    wfe_e = (f >= 0) && (wr_at[f] <= cyc) && ret[f];
    chk("req_ready", bus.REQ_READY, rdy_e);
    chk("wfe", bus.WFE, wfe_e);
    chk("w_f", bus.W_F, frees % NN);
    chk("pending", bus.PENDING, alloc_q.size());
    chk("err", bus.ERR, err_exp);
    accept(p1, 1);
    accept(p2, 2);
    if (s_rv) begin
      if (!is_alloc(int'(s_rn))) err_exp |= chk_en();
      ret[s_rn] = 1'b1;
    end
    if (wfe_e && s_fr) begin
      void'(alloc_q.pop_front());
      wr_at[f] = INF; ret[f] = 1'b0; frees++;
    end
    if (s_af) begin
      if (is_alloc(int'(s_an))) err_exp |= chk_en();
      alloc_q.push_back(int'(s_an));
      wr_at[s_an] = INF; ret[s_an] = 1'b0;
    end
    last = (p2 >= 0) ? p2 : p1;
    if (last >= 0) rr = (last + 1) % NR;
    cyc++;
  endtask

  task automatic rnd_stim(input bit allow_alloc, input bit drain);
    int cand[$], rc[$];
    clr();
    foreach (alloc_q[i]) begin
      if (wr_at[alloc_q[i]] == INF) cand.push_back(alloc_q[i]);
      if (!ret[alloc_q[i]]) rc.push_back(alloc_q[i]);
    end
    for (int i = 0; i < NR; i++) begin
      s_v[i] = (cand.size() != 0) && (drain || $urandom_range(1, 0) == 1);
      s_n[i] = (cand.size() != 0) ? NW'(cand[$urandom_range(cand.size()-1, 0)]) : NW'($urandom);
      s_d[i] = $urandom;
    end
    s_rv = (rc.size() != 0) && (drain || $urandom_range(1, 0) == 1);
    s_rn = (rc.size() != 0) ? NW'(rc[$urandom_range(rc.size()-1, 0)]) : '0;
    s_af = allow_alloc && (alloc_q.size() < NN) && ($urandom_range(1, 0) == 1);
    s_fr = drain || ($urandom_range(3, 0) != 0);
  endtask

  task automatic do_reset();
    @(negedge CLK); #1;
    RST = 1'b0;
    model_clear();
    s_v = '1; s_an = '0; drive();
    #1;
    chk("rst_ready", bus.REQ_READY, 0);
    chk("rst_we1", bus.WE_1, 0);
    chk("rst_we2", bus.WE_2, 0);
    chk("rst_name1", bus.NAME_IN_1, 0);
    chk("rst_d1", bus.D_IN_1, 0);
    chk("rst_wfe", bus.WFE, 0);
    chk("rst_pending", bus.PENDING, 0);
    chk("rst_err", bus.ERR, 0);
    clr(); drive();
    repeat (2) @(negedge CLK);
    #1 RST = 1'b1;
  endtask

  // monitor: every registered write must match the next queued expectation
  initial begin
    wr_t e;
    forever begin
      @(negedge CLK);
      if (RST) begin
        chk("we1", bus.WE_1, q1.size() != 0);
        if (q1.size() != 0) begin
          e = q1.pop_front();
          chk("name_in_1", bus.NAME_IN_1, e.name);
          chk("d_in_1", bus.D_IN_1, e.data);
        end
        chk("we2", bus.WE_2, q2.size() != 0);
        if (q2.size() != 0) begin
          e = q2.pop_front();
          chk("name_in_2", bus.NAME_IN_2, e.name);
          chk("d_in_2", bus.D_IN_2, e.data);
        end
      end
    end
  end

  initial begin
    cyc = 0;
    model_clear();
    clr();
    do_reset();

    // alloc 0,1 then two-port write, then same-name hold
    clr(); s_af = 1'b1; step();
    clr(); s_af = 1'b1; step();
    clr(); s_v = 4'b0101; s_n[0] = 2'd0; s_d[0] = 32'hA; s_n[2] = 2'd1; s_d[2] = 32'hB;
    s_af = 1'b1; step();
    clr(); s_af = 1'b1; step();
    clr(); s_v = 4'b1000; s_n[3] = 2'd3; s_d[3] = 32'h33; step();
    clr(); s_v = 4'b1010; s_n[1] = 2'd2; s_d[1] = 32'h21; s_n[3] = 2'd2; s_d[3] = 32'h23; step();
    clr(); s_v = 4'b1000; s_n[3] = 2'd2; s_d[3] = 32'h23; step();

    // retire out of order; frees must wait for name 0, then drain in order
    clr(); s_rv = 1'b1; s_rn = 2'd3; step();
    clr(); s_rv = 1'b1; s_rn = 2'd2; step();
    clr(); s_rv = 1'b1; s_rn = 2'd1; step();
    clr(); s_rv = 1'b1; s_rn = 2'd0; step();
    repeat (5) begin clr(); step(); end

    repeat (2000) begin rnd_stim(1'b1, 1'b0); step(); end
    repeat (60)   begin rnd_stim(1'b0, 1'b1); step(); end

    // write to an unallocated name: sticky ERR only with the checker compiled in
    clr(); s_v = 4'b0001; s_n[0] = 2'd3; s_d[0] = 32'hDEAD; step();
    repeat (3) begin clr(); step(); end
    repeat (20) begin rnd_stim(1'b1, 1'b0); step(); end

    // reset in the middle of traffic, then recover
    do_reset();
    repeat (200) begin rnd_stim(1'b1, 1'b0); step(); end
    repeat (60)  begin rnd_stim(1'b0, 1'b1); step(); end
    @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
